// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame receiver: FSM states and frame format constants.
`timescale 1ns/1ps
package uart_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GET_LEN,
      GET_CMD,
      GET_PAYLOAD,
      GET_CHK,
      HOLD
   } state_t;

   localparam logic [7:0] SYNC_BYTE   = 8'hA5;
   localparam int         MAX_PAYLOAD = 16;

endpackage

// File: rtl/frame_buf.sv
// Payload storage: 16x8 memory with one synchronous write port and a combinational read port.
`timescale 1ns/1ps
module frame_buf (
   input  logic       clk,
   input  logic       i_we,
   input  logic [3:0] i_waddr,
   input  logic [7:0] i_wdata,
   input  logic [3:0] i_raddr,
   output logic [7:0] o_rdata
);

   logic [7:0] r_mem [16];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Frame parser: SYNC, LEN, CMD, payload, XOR checksum; holds a good frame until acknowledged.
`timescale 1ns/1ps
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ   = 72_000_000,
   parameter int unsigned BAUD_RATE     = 115_200,
   parameter int unsigned TIMEOUT_CHARS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_error,
   output logic       frame_valid,
   output logic [7:0] frame_cmd,
   output logic [4:0] frame_len,
   input  logic       frame_ack,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       err_chk,
   output logic       err_len,
   output logic       err_timeout,
   output logic       err_uart,
   output logic [7:0] drop_cnt
);

   localparam int unsigned TIMEOUT_CYCLES = (CLK_FREQ_HZ / BAUD_RATE) * 10 * TIMEOUT_CHARS;

   state_t      r_state;
   state_t      w_nextState;
   logic [4:0]  r_len;
   logic [7:0]  r_cmd;
   logic [7:0]  r_chk;
   logic [3:0]  r_idx;
   logic [31:0] r_toCnt;
   logic [7:0]  r_dropCnt;
   logic        r_errChk;
   logic        r_errLen;
   logic        r_errTimeout;
   logic        r_errUart;

   logic w_active;
   logic w_byte;
   logic w_timeout;
   logic w_lastPayload;
   logic w_bufWe;
   logic w_errChk;
   logic w_errLen;
   logic w_errUart;

   assign w_active      = (r_state == GET_LEN) || (r_state == GET_CMD) ||
                          (r_state == GET_PAYLOAD) || (r_state == GET_CHK);
   assign w_byte        = rx_valid && !rx_error;
   assign w_timeout     = w_active && !rx_valid && !rx_error &&
                          (r_toCnt == 32'(TIMEOUT_CYCLES - 1));
   assign w_lastPayload = ({1'b0, r_idx} == (r_len - 5'd1));
   assign w_bufWe       = (r_state == GET_PAYLOAD) && w_byte;

   // A UART error outranks everything else while a frame is in progress, then the timeout.
   always_comb begin
      w_nextState = r_state;
      w_errChk    = 1'b0;
      w_errLen    = 1'b0;
      w_errUart   = 1'b0;
      if (w_active && rx_error) begin
         w_nextState = IDLE;
         w_errUart   = 1'b1;
      end else if (w_timeout) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_byte && (rx_data == SYNC_BYTE)) w_nextState = GET_LEN;
            end
            GET_LEN: begin
               if (rx_valid) begin
                  if (rx_data > 8'(MAX_PAYLOAD)) begin
                     w_nextState = IDLE;
                     w_errLen    = 1'b1;
                  end else begin
                     w_nextState = GET_CMD;
                  end
               end
            end
            GET_CMD: begin
               if (rx_valid) w_nextState = (r_len != 5'd0) ? GET_PAYLOAD : GET_CHK;
            end
            GET_PAYLOAD: begin
               if (rx_valid && w_lastPayload) w_nextState = GET_CHK;
            end
            GET_CHK: begin
               if (rx_valid) begin
                  if (rx_data == r_chk) begin
                     w_nextState = HOLD;
                  end else begin
                     w_nextState = IDLE;
                     w_errChk    = 1'b1;
                  end
               end
            end
            HOLD: begin
               if (frame_ack) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_len        <= '0;
         r_cmd        <= '0;
         r_chk        <= '0;
         r_idx        <= '0;
         r_toCnt      <= '0;
         r_dropCnt    <= '0;
         r_errChk     <= 1'b0;
         r_errLen     <= 1'b0;
         r_errTimeout <= 1'b0;
         r_errUart    <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_errChk     <= w_errChk;
         r_errLen     <= w_errLen;
         r_errTimeout <= w_timeout;
         r_errUart    <= w_errUart;
         r_toCnt      <= (w_active && !rx_valid && !rx_error && !w_timeout) ? r_toCnt + 32'd1 : '0;
         if ((r_state == HOLD) && rx_valid && (r_dropCnt != 8'hFF)) begin
            r_dropCnt <= r_dropCnt + 8'd1;
         end
         if (w_byte) begin
            case (r_state)
               GET_LEN: begin
                  if (rx_data <= 8'(MAX_PAYLOAD)) begin
                     r_len <= rx_data[4:0];
                     r_chk <= rx_data;
                     r_idx <= '0;
                  end
               end
               GET_CMD: begin
                  r_cmd <= rx_data;
                  r_chk <= r_chk ^ rx_data;
               end
               GET_PAYLOAD: begin
                  r_chk <= r_chk ^ rx_data;
                  r_idx <= r_idx + 4'd1;
               end
               default: ;
            endcase
         end
      end
   end

   frame_buf u_frame_buf (
      .clk     (clk),
      .i_we    (w_bufWe),
      .i_waddr (r_idx),
      .i_wdata (rx_data),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );

   assign frame_valid = (r_state == HOLD);
   assign frame_cmd   = r_cmd;
   assign frame_len   = r_len;
   assign drop_cnt    = r_dropCnt;
   assign err_chk     = r_errChk;
   assign err_len     = r_errLen;
   assign err_timeout = r_errTimeout;
   assign err_uart    = r_errUart;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: stimulus queues expected events, a monitor pops and checks them.
`timescale 1ns/1ps
module tb_uart_frame_rx;

   localparam int KIND_FRAME = 0;
   localparam int KIND_CHK   = 1;
   localparam int KIND_LEN   = 2;
   localparam int KIND_TO    = 3;
   localparam int KIND_UART  = 4;

   typedef struct packed {
      logic [2:0]   kind;
      logic [7:0]   cmd;
      logic [4:0]   len;
      logic [127:0] pay;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic       frame_valid;
   logic [7:0] frame_cmd;
   logic [4:0] frame_len;
   logic       frame_ack;
   logic [3:0] rd_addr = 4'd0;
   logic [7:0] rd_data;
   logic       err_chk;
   logic       err_len;
   logic       err_timeout;
   logic       err_uart;
   logic [7:0] drop_cnt;

   exp_t expQ[$];
   exp_t holdExp = '0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   uart_frame_rx dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_error    (rx_error),
      .frame_valid (frame_valid),
      .frame_cmd   (frame_cmd),
      .frame_len   (frame_len),
      .frame_ack   (frame_ack),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .err_chk     (err_chk),
      .err_len     (err_len),
      .err_timeout (err_timeout),
      .err_uart    (err_uart),
      .drop_cnt    (drop_cnt)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
      end
   endtask

   // Each byte is a one-cycle strobe; calls start and end at 1ns after a rising edge.
   task automatic applyStimulus(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic applySeq(input logic [191:0] seq, input int n);
      for (int i = 0; i < n; i++) applyStimulus(seq[8*(n-1-i) +: 8]);
   endtask

   task automatic pushExp(input int kind, input logic [7:0] cmd, input logic [4:0] len,
                          input logic [127:0] pay);
      exp_t e;
      e.kind = 3'(kind);
      e.cmd  = cmd;
      e.len  = len;
      e.pay  = pay;
      expQ.push_back(e);
   endtask

   task automatic waitDrain(input string name, input int maxCycles);
      int c = 0;
      while (expQ.size() != 0 && c < maxCycles) begin
         @(posedge clk);
         c++;
      end
      #1;
      total++;
      if (expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL %s: pending events=%0d, expected 0", name, expQ.size());
         expQ.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic ackFrame(input string name);
      frame_ack = 1'b1;
      @(posedge clk);
      #1;
      frame_ack = 1'b0;
      checkOutput(name, 32'(frame_valid), 32'd0);
   endtask

   task automatic popCheck(input int kind, input string name);
      exp_t e;
      total++;
      if (expQ.size() == 0) begin
         bad++;
         $display("[TB] FAIL %s: unexpected event, kind=%0d expected none", name, kind);
      end else begin
         e = expQ.pop_front();
         if (int'(e.kind) != kind) begin
            bad++;
            $display("[TB] FAIL %s: event kind=%0d, expected kind=%0d", name, kind, e.kind);
         end else if (kind == KIND_FRAME) begin
            holdExp = e;
         end
      end
   endtask

   // Monitor: any pulse or frame_valid rise consumes one expectation; held contents rechecked every cycle.
   initial begin
      logic prevFv;
      prevFv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevFv = 1'b0;
         end else begin
            if (err_chk)     popCheck(KIND_CHK,  "err_chk");
            if (err_len)     popCheck(KIND_LEN,  "err_len");
            if (err_timeout) popCheck(KIND_TO,   "err_timeout");
            if (err_uart)    popCheck(KIND_UART, "err_uart");
            if (frame_valid && !prevFv) popCheck(KIND_FRAME, "frame_valid");
            if (frame_valid) begin
               checkOutput("frame_cmd", 32'(frame_cmd), 32'(holdExp.cmd));
               checkOutput("frame_len", 32'(frame_len), 32'(holdExp.len));
               for (int i = 0; i < int'(holdExp.len); i++) begin
                  rd_addr = 4'(i);
                  #0.2;
                  checkOutput("rd_data", 32'(rd_data), 32'(holdExp.pay[8*i +: 8]));
               end
            end
            prevFv = frame_valid;
         end
      end
   end

   initial begin
      rst       = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      rx_error  = 1'b0;
      frame_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset frame_valid", 32'(frame_valid), 32'd0);
      checkOutput("reset frame_cmd",   32'(frame_cmd),   32'd0);
      checkOutput("reset frame_len",   32'(frame_len),   32'd0);
      checkOutput("reset drop_cnt",    32'(drop_cnt),    32'd0);
      checkOutput("reset errors", 32'({err_chk, err_len, err_timeout, err_uart}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic two-byte frame.
      pushExp(KIND_FRAME, 8'h10, 5'd2, 128'h2211);
      applySeq({8'hA5, 8'h02, 8'h10, 8'h11, 8'h22, 8'h21}, 6);
      waitDrain("frame A", 20);
      ackFrame("frame A released");

      // Ack outside HOLD is ignored, then empty-payload frame.
      frame_ack = 1'b1;
      @(posedge clk);
      #1;
      frame_ack = 1'b0;
      pushExp(KIND_FRAME, 8'h05, 5'd0, 128'h0);
      applySeq({8'hA5, 8'h00, 8'h05, 8'h05}, 4);
      waitDrain("frame B", 20);
      ackFrame("frame B released");

      // Bad checksum, then a good frame is still accepted.
      pushExp(KIND_CHK, 8'h00, 5'd0, 128'h0);
      applySeq({8'hA5, 8'h02, 8'h10, 8'h11, 8'h22, 8'h20}, 6);
      waitDrain("bad checksum", 20);
      checkOutput("no frame after bad chk", 32'(frame_valid), 32'd0);
      pushExp(KIND_FRAME, 8'h33, 5'd1, 128'h44);
      applySeq({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h33, 8'h44, 8'h76}, 8);
      waitDrain("frame C", 20);
      ackFrame("frame C released");

      // Length boundaries: 17 rejected, 16 accepted.
      pushExp(KIND_LEN, 8'h00, 5'd0, 128'h0);
      applySeq({8'hA5, 8'h11}, 2);
      waitDrain("length 17", 20);
      pushExp(KIND_FRAME, 8'h3C, 5'd16, 128'h0F0E0D0C0B0A09080706050403020100);
      applySeq({8'hA5, 8'h10, 8'h3C}, 3);
      for (int i = 0; i < 16; i++) applyStimulus(8'(i));
      applyStimulus(8'h2C);
      waitDrain("frame 16", 20);
      ackFrame("frame 16 released");

      // Reset mid-frame aborts silently.
      applySeq({8'hA5, 8'h02, 8'h10}, 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("mid-frame reset", 32'(frame_valid), 32'd0);
      pushExp(KIND_FRAME, 8'h10, 5'd2, 128'h2211);
      applySeq({8'hA5, 8'h02, 8'h10, 8'h11, 8'h22, 8'h21}, 6);
      waitDrain("frame after reset", 20);
      ackFrame("frame after reset released");

      // Inter-byte timeout.
      pushExp(KIND_TO, 8'h00, 5'd0, 128'h0);
      applySeq({8'hA5, 8'h01}, 2);
      waitDrain("timeout", 30000);

      // UART errors: mid-payload, simultaneous with a byte, and ignored in IDLE.
      pushExp(KIND_UART, 8'h00, 5'd0, 128'h0);
      applySeq({8'hA5, 8'h03, 8'h07, 8'h01}, 4);
      rx_error = 1'b1;
      @(posedge clk);
      #1;
      rx_error = 1'b0;
      waitDrain("uart error payload", 20);
      applyStimulus(8'hA5);
      pushExp(KIND_UART, 8'h00, 5'd0, 128'h0);
      rx_data  = 8'h02;
      rx_valid = 1'b1;
      rx_error = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_error = 1'b0;
      waitDrain("uart error with byte", 20);
      rx_error = 1'b1;
      @(posedge clk);
      #1;
      rx_error = 1'b0;

      // Held frame absorbs 300 bytes; drop counter saturates, contents stay put.
      pushExp(KIND_FRAME, 8'h42, 5'd1, 128'h99);
      applySeq({8'hA5, 8'h01, 8'h42, 8'h99, 8'hDA}, 5);
      waitDrain("frame D", 20);
      for (int i = 0; i < 10; i++) applyStimulus(8'hA5);
      checkOutput("drop_cnt 10", 32'(drop_cnt), 32'd10);
      rx_error = 1'b1;
      @(posedge clk);
      #1;
      rx_error = 1'b0;
      for (int i = 10; i < 300; i++) applyStimulus(8'(i));
      checkOutput("drop_cnt saturated", 32'(drop_cnt), 32'd255);
      checkOutput("still held", 32'(frame_valid), 32'd1);
      ackFrame("frame D released");
      checkOutput("drop_cnt kept", 32'(drop_cnt), 32'd255);
      repeat (3) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 72_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate used for timeout sizing.
REQ-003 SHALL have parameter TIMEOUT_CHARS, default 4, inter-byte timeout in character times (10 bits each).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx_data  input  8  received byte from the UART receiver wrapper.
REQ-007 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid.
REQ-008 SHALL have port rx_error  input  1  UART framing/overrun indication.
REQ-009 SHALL have port frame_valid  output  1  complete, checksum-good frame held.
REQ-010 SHALL have port frame_cmd  output  8  command byte of held frame.
REQ-011 SHALL have port frame_len  output  5  payload length of held frame, 0..16.
REQ-012 SHALL have port frame_ack  input  1  consumer releases held frame.
REQ-013 SHALL have port rd_addr  input  4  payload buffer read index.
REQ-014 SHALL have port rd_data  output  8  payload byte at rd_addr, combinational read.
REQ-015 SHALL have ports err_chk, err_len, err_timeout, err_uart  output  1 each  one-cycle error pulses.
REQ-016 SHALL have port drop_cnt  output  8  saturating count of bytes discarded while a frame is held.

Function
REQ-017 Frame format SHALL be SYNC(0xA5), LEN, CMD, LEN payload bytes, CHK; CHK = XOR of LEN, CMD and all payload bytes.
REQ-018 States SHALL be IDLE, GET_LEN, GET_CMD, GET_PAYLOAD, GET_CHK, HOLD; each state consumes exactly one byte per rx_valid, except HOLD.
REQ-019 IDLE: rx_valid with rx_data==0xA5 -> GET_LEN; any other byte ignored, no error.
REQ-020 GET_LEN: rx_data>16 -> IDLE with err_len pulse; else latch length, seed checksum with rx_data -> GET_CMD.
REQ-021 GET_CMD: latch cmd, XOR into checksum -> GET_PAYLOAD if length>0, else GET_CHK.
REQ-022 GET_PAYLOAD: write byte at index (starting 0), XOR into checksum, increment index; after byte index length-1 -> GET_CHK.
REQ-023 GET_CHK: match -> HOLD, frame_valid high the cycle after that rx_valid; mismatch -> IDLE with err_chk pulse.
REQ-024 HOLD: frame_valid, frame_cmd, frame_len, buffer contents stable until frame_ack; on frame_ack -> IDLE next cycle, frame_valid low.
REQ-025 HOLD: every rx_valid SHALL be discarded and increment drop_cnt, saturating at 255; includes a byte arriving in the same cycle as frame_ack.
REQ-026 rx_error in GET_LEN..GET_CHK -> IDLE with err_uart pulse; rx_error in IDLE or HOLD ignored; rx_error with rx_valid same cycle: error wins, byte discarded.
REQ-027 Timeout counter SHALL clear on each rx_valid and count otherwise; reaching (CLK_FREQ_HZ/BAUD_RATE)*10*TIMEOUT_CHARS in GET_LEN..GET_CHK -> IDLE with err_timeout pulse; inactive in IDLE and HOLD.
REQ-028 Error pulses SHALL be exactly one cycle wide, asserted the cycle after the causing event; at most one per event.
REQ-029 frame_ack outside HOLD SHALL be ignored.

Reset
REQ-030 On rst: state IDLE; frame_valid, frame_cmd, frame_len, all err_* and drop_cnt 0; checksum, index, timeout counter 0; buffer contents need not clear.
REQ-031 rst asserted mid-frame or in HOLD SHALL abort immediately with no error pulse.

Structure
REQ-032 Package uart_frame_pkg SHALL hold the state enum, SYNC_BYTE=8'hA5 and MAX_PAYLOAD=16.
REQ-033 Payload storage SHALL be a sub-module frame_buf (16x8, one synchronous write port, one combinational read port).

Verification
REQ-034 Bytes A5 02 10 11 22 21 -> frame_valid=1, frame_cmd=0x10, frame_len=2, rd_addr 0/1 give 0x11/0x22; no error pulses.
REQ-035 Bytes A5 00 05 05 -> frame_valid=1, frame_len=0, frame_cmd=0x05; frame_ack -> frame_valid=0 next cycle.
REQ-036 Bytes A5 02 10 11 22 20 -> err_chk single pulse, frame_valid stays 0, next valid frame accepted.
REQ-037 Bytes A5 11 -> err_len pulse, return to IDLE; A5 01 then idle 4x625x10+ cycles -> err_timeout pulse.
REQ-038 Held frame plus 300 extra bytes -> drop_cnt=255, frame contents unchanged; rx_error during GET_PAYLOAD -> err_uart pulse.
